// File: rtl/herald_host_bridge.sv
// Byte-serial host bridge: collects a command byte plus operands from the 8-bit host pins,
// hands them to a compute engine over valid/ready, and streams the result back byte by byte.
module herald_host_bridge #(
    parameter int DATA_W      = 24,
    parameter int MAX_OPS     = 2,
    parameter int RES_W       = 72,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  host_din,
    input  logic                        host_wr,
    input  logic                        host_rd,
    input  logic                        host_abort,
    output logic [7:0]                  host_dout,
    output logic                        host_busy,
    output logic                        host_avail,
    output logic                        host_err,
    output logic                        cmd_valid,
    input  logic                        cmd_ready,
    output logic [7:0]                  cmd_opcode,
    output logic [MAX_OPS*DATA_W-1:0]   cmd_operands,
    input  logic                        res_valid,
    output logic                        res_ready,
    input  logic [RES_W-1:0]            res_data,
    input  logic [7:0]                  res_bytes
);

    localparam int OB  = DATA_W / 8;
    localparam int RB  = RES_W / 8;
    localparam int BCW = (OB > 1) ? $clog2(OB) : 1;
    localparam int WDW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [7:0] RB8  = 8'(RB);
    localparam logic [1:0] MAXN = 2'(MAX_OPS);
    localparam bit         WD_EN = (TIMEOUT_CYC != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPERAND,
        S_ISSUE,
        S_WAIT_RES,
        S_DRAIN
    } state_t;

    state_t                      state_q, state_d;
    logic                        wr_q, rd_q;
    logic                        wr_edge, rd_edge;
    logic [7:0]                  opcode_q;
    logic [MAX_OPS*DATA_W-1:0]   operands_q;
    logic [BCW-1:0]              byte_cnt;
    logic [1:0]                  op_cnt;
    logic [WDW-1:0]              wd_cnt;
    logic [RES_W-1:0]            res_buf;
    logic [7:0]                  res_len;
    logic [7:0]                  rd_idx;
    logic                        err_q;
    logic [7:0]                  dout_q;

    logic [1:0]                  n_in;
    logic [1:0]                  n_cur;
    logic                        last_byte;
    logic                        last_op;
    logic                        wd_hit;
    logic [7:0]                  res_len_in;

    assign wr_edge    = host_wr & ~wr_q;
    assign rd_edge    = host_rd & ~rd_q;
    assign n_in       = host_din[7:6];
    assign n_cur      = opcode_q[7:6];
    assign last_byte  = (byte_cnt == BCW'(OB - 1));
    assign last_op    = (op_cnt == n_cur - 2'd1);
    assign wd_hit     = WD_EN && (wd_cnt == WDW'(TIMEOUT_CYC - 1));
    assign res_len_in = (res_bytes > RB8) ? RB8 : res_bytes;

    assign cmd_opcode   = opcode_q;
    assign cmd_operands = operands_q;
    assign host_dout    = dout_q;
    assign host_err     = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Abort masks the handshakes combinationally so the engine never sees a
    // transfer that the bridge is about to discard.
    always_comb begin
        state_d    = state_q;
        cmd_valid  = 1'b0;
        res_ready  = 1'b0;
        host_busy  = 1'b0;
        host_avail = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wr_edge && n_in <= MAXN)
                    state_d = (n_in == 2'd0) ? S_ISSUE : S_OPERAND;
            end
            S_OPERAND: begin
                if (wr_edge && last_byte && last_op) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                cmd_valid = 1'b1;
                host_busy = 1'b1;
                if (cmd_ready)   state_d = S_WAIT_RES;
                else if (wd_hit) state_d = S_IDLE;
            end
            S_WAIT_RES: begin
                res_ready = 1'b1;
                host_busy = 1'b1;
                if (res_valid)   state_d = (res_len_in == 8'd0) ? S_IDLE : S_DRAIN;
                else if (wd_hit) state_d = S_IDLE;
            end
            S_DRAIN: begin
                host_avail = 1'b1;
                if (rd_edge && rd_idx == res_len - 8'd1) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (host_abort) begin
            state_d   = S_IDLE;
            cmd_valid = 1'b0;
            res_ready = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q       <= 1'b0;
            rd_q       <= 1'b0;
            opcode_q   <= '0;
            operands_q <= '0;
            byte_cnt   <= '0;
            op_cnt     <= '0;
            wd_cnt     <= '0;
            res_buf    <= '0;
            res_len    <= '0;
            rd_idx     <= '0;
            err_q      <= 1'b0;
            dout_q     <= '0;
        end else begin
            wr_q <= host_wr;
            rd_q <= host_rd;
            if (host_abort) begin
                byte_cnt <= '0;
                op_cnt   <= '0;
                wd_cnt   <= '0;
                rd_idx   <= '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (wr_edge) begin
                            opcode_q   <= host_din;
                            operands_q <= '0;
                            err_q      <= (n_in > MAXN);
                            byte_cnt   <= '0;
                            op_cnt     <= '0;
                            wd_cnt     <= '0;
                        end
                    end
                    S_OPERAND: begin
                        if (wr_edge) begin
                            for (int k = 0; k < MAX_OPS; k++)
                                for (int j = 0; j < OB; j++)
                                    if (op_cnt == 2'(k) && byte_cnt == BCW'(j))
                                        operands_q[k*DATA_W + 8*j +: 8] <= host_din;
                            if (last_byte) begin
                                byte_cnt <= '0;
                                op_cnt   <= op_cnt + 2'd1;
                            end else begin
                                byte_cnt <= byte_cnt + 1'b1;
                            end
                        end
                    end
                    S_ISSUE: begin
                        wd_cnt <= wd_cnt + 1'b1;
                        if (!cmd_ready && wd_hit) err_q <= 1'b1;
                    end
                    S_WAIT_RES: begin
                        wd_cnt <= wd_cnt + 1'b1;
                        if (res_valid) begin
                            res_buf <= res_data;
                            res_len <= res_len_in;
                            rd_idx  <= '0;
                        end else if (wd_hit) begin
                            err_q <= 1'b1;
                        end
                    end
                    S_DRAIN: begin
                        // Result is kept as a shift register; byte 0 is always at the bottom.
                        if (rd_edge) begin
                            dout_q  <= res_buf[7:0];
                            res_buf <= res_buf >> 8;
                            rd_idx  <= rd_idx + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_herald_host_bridge.sv
// Self-checking bench for herald_host_bridge: a transaction-level model predicts every output
// each cycle, and directed tests pin the model with hand-computed literals.
module tb_herald_host_bridge;

    localparam int DW = 24;
    localparam int MO = 2;
    localparam int RW = 72;
    localparam int TO = 16;
    localparam int RB = RW / 8;
    localparam int OB = DW / 8;

    localparam int P_IDLE = 0, P_OPND = 1, P_ISSUE = 2, P_WAIT = 3, P_DRAIN = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [7:0]      host_din;
    logic            host_wr, host_rd, host_abort;
    logic [7:0]      host_dout;
    logic            host_busy, host_avail, host_err;
    logic            cmd_valid, cmd_ready;
    logic [7:0]      cmd_opcode;
    logic [MO*DW-1:0] cmd_operands;
    logic            res_valid, res_ready;
    logic [RW-1:0]   res_data;
    logic [7:0]      res_bytes;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    herald_host_bridge #(.DATA_W(DW), .MAX_OPS(MO), .RES_W(RW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .host_din(host_din), .host_wr(host_wr), .host_rd(host_rd), .host_abort(host_abort),
        .host_dout(host_dout), .host_busy(host_busy), .host_avail(host_avail), .host_err(host_err),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_operands(cmd_operands),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_bytes(res_bytes)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: protocol phase, operand stream position, result byte queue.
    int          ph;
    logic [7:0]  m_op;
    logic [MO*DW-1:0] m_opnds;
    bit          m_err;
    logic [7:0]  m_dout;
    int          nb, need, wd, len;
    bit          pwr, prd, we, re;
    logic [7:0]  rq[$];

    initial begin
        forever begin
            @(posedge clk);
            we = host_wr & ~pwr;
            re = host_rd & ~prd;
            if (!rst_n) begin
                ph = P_IDLE; m_op = 0; m_opnds = 0; m_err = 0; m_dout = 0;
                wd = 0; nb = 0; need = 0; rq.delete(); pwr = 0; prd = 0;
            end else begin
                pwr = host_wr;
                prd = host_rd;
                if (host_abort) begin
                    ph = P_IDLE;
                end else begin
                    case (ph)
                        P_IDLE: if (we) begin
                            m_op = host_din; m_opnds = 0; m_err = 0; nb = 0;
                            need = int'(host_din[7:6]) * OB;
                            wd = 0;
                            if (int'(host_din[7:6]) > MO) m_err = 1;
                            else ph = (need == 0) ? P_ISSUE : P_OPND;
                        end
                        P_OPND: if (we) begin
                            m_opnds[8*nb +: 8] = host_din;
                            nb++;
                            if (nb == need) begin ph = P_ISSUE; wd = 0; end
                        end
                        P_ISSUE: begin
                            wd++;
                            if (cmd_ready) ph = P_WAIT;
                            else if (TO != 0 && wd == TO) begin m_err = 1; ph = P_IDLE; end
                        end
                        P_WAIT: begin
                            wd++;
                            if (res_valid) begin
                                len = (int'(res_bytes) > RB) ? RB : int'(res_bytes);
                                rq.delete();
                                for (int i = 0; i < len; i++) rq.push_back(res_data[8*i +: 8]);
                                ph = (len == 0) ? P_IDLE : P_DRAIN;
                            end else if (TO != 0 && wd == TO) begin
                                m_err = 1; ph = P_IDLE;
                            end
                        end
                        P_DRAIN: if (re) begin
                            m_dout = rq.pop_front();
                            if (rq.size() == 0) ph = P_IDLE;
                        end
                        default: ph = P_IDLE;
                    endcase
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_dout",     host_dout,    m_dout);
            chk("m_err",      host_err,     m_err);
            chk("m_busy",     host_busy,    (ph == P_ISSUE || ph == P_WAIT));
            chk("m_avail",    host_avail,   (ph == P_DRAIN));
            chk("m_cmdvalid", cmd_valid,    (ph == P_ISSUE) && !host_abort);
            chk("m_resready", res_ready,    (ph == P_WAIT) && !host_abort);
            chk("m_opcode",   cmd_opcode,   m_op);
            chk("m_operands", cmd_operands, m_opnds);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_byte(input logic [7:0] b);
        host_din = b; host_wr = 1'b1;
        tick();
        host_wr = 1'b0;
        tick();
    endtask

    task automatic rd_pulse();
        host_rd = 1'b1;
        tick();
        host_rd = 1'b0;
        tick();
    endtask

    int nv;
    bit av;

    initial begin
        rst_n = 1'b0; host_din = 0; host_wr = 0; host_rd = 0; host_abort = 0;
        cmd_ready = 0; res_valid = 0; res_data = 0; res_bytes = 0;
        tick(); tick();
        chk("rst_dout",  host_dout, 0);
        chk("rst_busy",  host_busy, 0);
        chk("rst_avail", host_avail, 0);
        chk("rst_err",   host_err, 0);
        chk("rst_valid", cmd_valid, 0);
        chk("rst_ready", res_ready, 0);
        chk("rst_opnds", cmd_operands, 0);
        rst_n = 1'b1;
        chk_en = 1;
        tick();

        // MUL with two 3-byte operands
        wr_byte(8'h80);
        wr_byte(8'h00); wr_byte(8'h10); wr_byte(8'h00);
        wr_byte(8'h00); wr_byte(8'h20); wr_byte(8'h00);
        chk("mul_opnds",  cmd_operands, 48'h002000_001000);
        chk("mul_opcode", cmd_opcode, 8'h80);
        chk("mul_valid",  cmd_valid, 1);
        cmd_ready = 1; tick(); cmd_ready = 0;
        chk("mul_rready", res_ready, 1);
        res_data = 72'h002000; res_bytes = 8'd3; res_valid = 1; tick(); res_valid = 0;
        chk("mul_avail", host_avail, 1);
        rd_pulse(); chk("mul_b0", host_dout, 8'h00);
        rd_pulse(); chk("mul_b1", host_dout, 8'h20);
        rd_pulse(); chk("mul_b2", host_dout, 8'h00);
        chk("mul_avail_off", host_avail, 0);

        // n = 0, zero-length result, engine tied ready/valid: 3-cycle loop
        host_din = 8'h22; cmd_ready = 1; res_valid = 1; res_bytes = 0; host_wr = 1;
        nv = 0; av = 0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            host_wr = 0;
            if (cmd_valid) nv++;
            if (host_avail) av = 1;
            if (i == 2) chk("clr_busy2", host_busy, 1);
            if (i == 3) chk("clr_idle3", host_busy, 0);
        end
        chk("clr_pulses", nv, 1);
        chk("clr_avail",  av, 0);
        cmd_ready = 0; res_valid = 0;

        // 12-byte result clamped to 9; 5th read also carries a dropped write
        wr_byte(8'h00);
        cmd_ready = 1; tick(); cmd_ready = 0;
        res_data = 72'h99_88_77_66_55_44_33_22_11; res_bytes = 8'd12; res_valid = 1;
        tick(); res_valid = 0;
        for (int i = 0; i < 9; i++) begin
            host_rd = 1;
            if (i == 4) begin host_din = 8'h40; host_wr = 1; end
            tick();
            host_rd = 0; host_wr = 0;
            chk("clamp_byte", host_dout, 8'(8'h11 * (i + 1)));
            tick();
        end
        chk("clamp_avail", host_avail, 0);
        chk("clamp_busy",  host_busy, 0);
        rd_pulse();
        chk("clamp_extra", host_dout, 8'h99);

        // Watchdog with cmd_ready held low
        host_din = 8'h05; host_wr = 1; tick(); host_wr = 0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 15) chk("to_valid15", cmd_valid, 1);
        end
        chk("to_err",   host_err, 1);
        chk("to_valid", cmd_valid, 0);
        chk("to_busy",  host_busy, 0);
        wr_byte(8'h40);
        chk("to_errclr", host_err, 0);
        wr_byte(8'h0A); wr_byte(8'h0B); wr_byte(8'h0C);
        chk("to_opnds", cmd_operands, 48'h000000_0C0B0A);
        cmd_ready = 1; tick(); cmd_ready = 0;
        res_bytes = 0; res_valid = 1; tick(); res_valid = 0;
        chk("to_done", host_busy, 0);

        // Operand count above MAX_OPS
        wr_byte(8'hC0);
        chk("inv_err",   host_err, 1);
        chk("inv_busy",  host_busy, 0);
        chk("inv_valid", cmd_valid, 0);
        tick(); tick();

        // Abort after two operand bytes, with a simultaneous write edge
        wr_byte(8'h81); wr_byte(8'hAA); wr_byte(8'hBB);
        host_abort = 1; host_din = 8'h00; host_wr = 1; tick();
        host_abort = 0; tick();
        host_wr = 0; tick();
        chk("abort_busy", host_busy, 0);
        wr_byte(8'h41);
        wr_byte(8'h01); wr_byte(8'h02); wr_byte(8'h03);
        chk("abort_opnds",  cmd_operands, 48'h000000_030201);
        chk("abort_opcode", cmd_opcode, 8'h41);
        cmd_ready = 1; tick(); cmd_ready = 0;
        res_data = 72'h5A; res_bytes = 8'd1; res_valid = 1; tick(); res_valid = 0;
        rd_pulse();
        chk("abort_res", host_dout, 8'h5A);

        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
